alu_muldiv_seq: RTL

Multi-cycle multiply/divide sequencer sitting beside the 16-bit EX-stage ALU. It accepts one operation from EX, iterates one bit per cycle using an internal adder/subtractor, stalls the pipeline through `busy`, and returns a double-width result with a one-cycle `done` pulse. The hazard logic uses `busy` to freeze IF/ID/EX; writeback takes `hi`/`lo` on `done`.

---
 rtl/alu_muldiv_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer beside the EX-stage ALU.
// Optional divide path is built only when MULDIV_DIV_EN is defined; otherwise every request is MUL.
module alu_muldiv_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  acc_q, acc_d;   // partial product high half / running remainder
   logic [WIDTH-1:0]  mq_q, mq_d;     // multiplier shifting out / dividend-quotient
   logic [WIDTH-1:0]  b_q, b_d;       // multiplicand / divisor
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;

   logic [WIDTH:0]    mul_sum;
   logic [WIDTH-1:0]  mul_acc, mul_mq;
   logic [WIDTH-1:0]  step_acc, step_mq;

   always_comb begin
      mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
      mul_acc = mul_sum[WIDTH:1];
      mul_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
   end

`ifdef MULDIV_DIV_EN
   logic              op_q, op_d;
   logic              dz_q, dz_d;
   logic [WIDTH:0]    rem_sh;
   logic [WIDTH+1:0]  trial;
   logic              borrow;
   logic [WIDTH-1:0]  div_acc, div_mq;

   always_comb begin
      rem_sh  = {acc_q, mq_q[WIDTH-1]};
      trial   = {1'b0, rem_sh} - {2'b00, b_q};
      borrow  = trial[WIDTH+1];
      // rem_sh < 2*divisor, so when the trial borrows the dropped MSB is always 0
      div_acc = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      div_mq  = {mq_q[WIDTH-2:0], ~borrow};
      step_acc = op_q ? div_acc : mul_acc;
      step_mq  = op_q ? div_mq : mul_mq;
   end

   assign dz = dz_q;
`else
   logic unused_op;

   assign unused_op = op;
   assign step_acc  = mul_acc;
   assign step_mq   = mul_mq;
   assign dz        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
      op_d    = op_q;
      dz_d    = dz_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = CntW'(WIDTH);
               b_d     = opa;
               mq_d    = opb;
               state_d = StRun;
`ifdef MULDIV_DIV_EN
               op_d = op;
               if (op) begin
                  b_d  = opb;
                  mq_d = opa;
                  if (opb == '0) begin
                     hi_d    = opa;
                     lo_d    = '1;
                     dz_d    = 1'b1;
                     state_d = StDone;
                  end
               end
`endif
            end
         end
         StRun: begin
            acc_d = step_acc;
            mq_d  = step_mq;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               hi_d    = step_acc;
               lo_d    = step_mq;
               state_d = StDone;
`ifdef MULDIV_DIV_EN
               dz_d = 1'b0;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULDIV_DIV_EN
         op_q    <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
         op_q    <= op_d;
         dz_q    <= dz_d;
`endif
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
